// File: rtl/countdown_timer.sv
// Countdown timer with a prescaled tick, pause/hold, optional auto-reload at
// terminal count and a one-cycle done pulse. Three-state FSM: IDLE, RUN, HOLD.
`timescale 1ns/1ps

module countdown_timer #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned PRESCALE = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             start,
    input  logic             pause,
    input  logic             auto_reload,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             done
);

    localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic [PW-1:0]    presc_q, presc_d;
    logic             done_q, done_d;

    // State and datapath registers; reset clears everything asynchronously.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            count_q  <= '0;
            reload_q <= '0;
            presc_q  <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            reload_q <= reload_d;
            presc_q  <= presc_d;
            done_q   <= done_d;
        end
    end

    // Next-state logic: load overrides everything, then start/pause, then the tick.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        reload_d = reload_q;
        presc_d  = presc_q;
        done_d   = 1'b0;

        if (load) begin
            count_d  = load_value;
            reload_d = load_value;
            presc_d  = '0;
            state_d  = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start && (count_q != '0)) begin
                        state_d = RUN;
                        presc_d = '0;
                    end
                end
                RUN: begin
                    if (pause) begin
                        state_d = HOLD;
                    end else if (presc_q == PRESC_LAST) begin
                        presc_d = '0;
                        if (count_q == WIDTH'(1)) begin
                            done_d = 1'b1;
                            if (auto_reload) begin
                                count_d = reload_q;
                            end else begin
                                count_d = '0;
                                state_d = IDLE;
                            end
                        end else if (count_q != '0) begin
                            count_d = count_q - WIDTH'(1);
                        end
                    end else begin
                        presc_d = presc_q + PW'(1);
                    end
                end
                HOLD: begin
                    if (!pause) begin
                        state_d = RUN;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // Outputs are taken straight from registered state.
    always_comb begin
        count = count_q;
        busy  = (state_q == RUN) || (state_q == HOLD);
        done  = done_q;
    end

endmodule

// File: tb/tb_countdown_timer.sv
// Self-checking bench: two timers (PRESCALE 1 and 4) share one stimulus and are
// compared every cycle against a behavioural model, plus literal expectations
// for the directed scenarios.
`timescale 1ns/1ps

module tb_countdown_timer;

    logic       clock = 1'b0;
    logic       reset;
    logic       load;
    logic [7:0] load_value;
    logic       start;
    logic       pause;
    logic       auto_reload;
    logic [7:0] count1, count4;
    logic       busy1, busy4, done1, done4;

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural model state, index 0 -> PRESCALE 1, index 1 -> PRESCALE 4.
    int m_count[2];
    int m_reload[2];
    int m_phase[2];
    bit m_busy[2];
    bit m_hold[2];
    bit m_done[2];
    int m_presc[2] = '{1, 4};

    always #5 clock = ~clock;

    countdown_timer #(.WIDTH(8), .PRESCALE(1)) dut1 (
        .clock(clock), .reset(reset), .load(load), .load_value(load_value),
        .start(start), .pause(pause), .auto_reload(auto_reload),
        .count(count1), .busy(busy1), .done(done1)
    );

    countdown_timer #(.WIDTH(8), .PRESCALE(4)) dut4 (
        .clock(clock), .reset(reset), .load(load), .load_value(load_value),
        .start(start), .pause(pause), .auto_reload(auto_reload),
        .count(count4), .busy(busy4), .done(done4)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_reset(int k);
        m_count[k] = 0; m_reload[k] = 0; m_phase[k] = 0;
        m_busy[k] = 0; m_hold[k] = 0; m_done[k] = 0;
    endfunction

    function automatic void model_step(int k);
        m_done[k] = 0;
        if (load) begin
            m_count[k] = load_value; m_reload[k] = load_value;
            m_phase[k] = 0; m_busy[k] = 0; m_hold[k] = 0;
        end else if (!m_busy[k]) begin
            if (start && m_count[k] != 0) begin
                m_busy[k] = 1; m_hold[k] = 0; m_phase[k] = 0;
            end
        end else if (m_hold[k]) begin
            if (!pause) m_hold[k] = 0;
        end else if (pause) begin
            m_hold[k] = 1;
        end else if (m_phase[k] + 1 == m_presc[k]) begin
            m_phase[k] = 0;
            if (m_count[k] == 1) begin
                m_done[k] = 1;
                if (auto_reload) m_count[k] = m_reload[k];
                else begin m_count[k] = 0; m_busy[k] = 0; end
            end else begin
                m_count[k] = m_count[k] - 1;
            end
        end else begin
            m_phase[k] = m_phase[k] + 1;
        end
    endfunction

    task automatic check_model();
        check("count_p1", count1, m_count[0]);
        check("busy_p1",  busy1,  m_busy[0]);
        check("done_p1",  done1,  m_done[0]);
        check("count_p4", count4, m_count[1]);
        check("busy_p4",  busy4,  m_busy[1]);
        check("done_p4",  done4,  m_done[1]);
    endtask

    // One rising edge: advance the model from the inputs seen at the edge, then check.
    task automatic cycle();
        @(posedge clock);
        for (int k = 0; k < 2; k++) begin
            if (!reset) model_reset(k);
            else model_step(k);
        end
        #1;
        check_model();
    endtask

    task automatic idle_inputs();
        load = 0; start = 0; pause = 0; auto_reload = 0;
    endtask

    task automatic do_load(input int v);
        load = 1; load_value = 8'(v);
        cycle();
        load = 0;
    endtask

    // Assert reset between edges and check that outputs clear without a clock.
    task automatic async_reset();
        #2;
        reset = 0;
        #1;
        for (int k = 0; k < 2; k++) model_reset(k);
        check("async_count", count1, 0);
        check("async_busy",  busy1,  0);
        check_model();
    endtask

    initial begin
        reset = 0; load = 0; load_value = 0; start = 0; pause = 0; auto_reload = 0;
        for (int k = 0; k < 2; k++) model_reset(k);
        #3;
        check("rst_count", count1, 0);
        check("rst_busy",  busy1,  0);
        check("rst_done",  done1,  0);
        cycle();
        cycle();
        reset = 1;

        // PRESCALE=1, load 3: 2,1,0 then done after the third tick.
        do_load(3);
        start = 1;
        cycle();
        start = 0;
        check("r030_busyE", busy1, 1);
        for (int i = 1; i <= 4; i++) begin
            cycle();
            check("r030_count", count1, (i <= 3) ? 3 - i : 0);
            check("r030_busy",  busy1,  (i < 3) ? 1 : 0);
            check("r030_done",  done1,  (i == 3) ? 1 : 0);
        end

        // PRESCALE=4, load 2: decrements at E+4 and E+8.
        do_load(2);
        start = 1;
        cycle();
        start = 0;
        for (int i = 1; i <= 9; i++) begin
            cycle();
            check("r031_count", count4, (i < 4) ? 2 : (i < 8) ? 1 : 0);
            check("r031_done",  done4,  (i == 8) ? 1 : 0);
        end

        // Pause after the first tick, then resume.
        do_load(5);
        start = 1;
        cycle();
        start = 0;
        cycle();
        check("r032_tick", count1, 4);
        pause = 1;
        for (int i = 0; i < 3; i++) begin
            cycle();
            check("r032_hold", count1, 4);
            check("r032_busy", busy1, 1);
        end
        pause = 0;
        for (int i = 0; i < 6; i++) cycle();
        check("r032_end", count1, 0);

        // Auto-reload: 1,2,1,2,1,2 with done on every reload.
        auto_reload = 1;
        do_load(2);
        start = 1;
        cycle();
        start = 0;
        for (int i = 1; i <= 6; i++) begin
            cycle();
            check("r033_count", count1, (i % 2 == 1) ? 1 : 2);
            check("r033_done",  done1,  (i % 2 == 0) ? 1 : 0);
        end
        // Load mid-run aborts with no done.
        do_load(200);
        check("r034_ld_count", count1, 200);
        check("r034_ld_busy",  busy1,  0);
        check("r034_ld_done",  done1,  0);
        auto_reload = 0;
        do_load(0);
        start = 1;
        cycle();
        cycle();
        start = 0;
        check("r034_z_busy", busy1, 0);
        check("r034_z_done", done1, 0);

        // Reset mid-run, inputs ignored during reset, start without load ignored.
        do_load(9);
        start = 1;
        cycle();
        start = 0;
        cycle();
        cycle();
        async_reset();
        load = 1; load_value = 8'd7; start = 1;
        cycle();
        cycle();
        load = 0;
        reset = 1;
        cycle();
        start = 0;
        check("r035_busy",  busy1,  0);
        check("r035_count", count1, 0);

        // Randomized phase.
        for (int n = 0; n < 3000; n++) begin
            load        = ($urandom_range(0, 19) == 0);
            load_value  = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255))
                                                      : 8'($urandom_range(0, 6));
            start       = ($urandom_range(0, 4) == 0);
            pause       = ($urandom_range(0, 4) == 0);
            auto_reload = ($urandom_range(0, 1) == 1);
            if (!reset) reset = 1;
            if ($urandom_range(0, 199) == 0) async_reset();
            cycle();
        end
        idle_inputs();
        reset = 1;
        cycle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/countdown_timer.md
COUNTDOWN_TIMER -- requirements
Module: countdown_timer

Interface
REQ-001 Parameter WIDTH, default 8: width of the count and load value.
REQ-002 Parameter PRESCALE, default 1: clock cycles per decrement, legal range 1..256.
REQ-003 Port clock, input, 1: single clock; all state changes on its rising edge.
REQ-004 Port reset, input, 1: asynchronous, active-low reset.
REQ-005 Port load, input, 1: capture load_value into count and reload register.
REQ-006 Port load_value, input, WIDTH: value to load.
REQ-007 Port start, input, 1: begin counting down from the current count.
REQ-008 Port pause, input, 1: level; freezes counting while high.
REQ-009 Port auto_reload, input, 1: level; restart from the reload register at terminal count.
REQ-010 Port count, output, WIDTH: current count value, registered.
REQ-011 Port busy, output, 1: high in states RUN and HOLD.
REQ-012 Port done, output, 1: one-cycle pulse at terminal count, registered.

Function
REQ-013 The FSM SHALL have the states IDLE, RUN and HOLD; the prescaler SHALL be an internal counter from 0 to PRESCALE-1.
REQ-014 When load=1 in any state, the block SHALL set count and reload to load_value, clear the prescaler, enter IDLE and suppress done on that cycle.
REQ-015 Priority SHALL be load > start, and load > pause > decrement.
REQ-016 In IDLE, start=1 with count!=0 SHALL enter RUN at the same edge with the prescaler at 0; start with count==0 SHALL be ignored (stay IDLE, no done).
REQ-017 start in RUN or HOLD SHALL be ignored.
REQ-018 In RUN with pause=0, the prescaler SHALL increment each cycle; at PRESCALE-1 it SHALL wrap to 0 and count SHALL decrement by 1 (a tick).
REQ-019 The first decrement SHALL occur PRESCALE cycles after the edge that captured start.
REQ-020 In RUN, pause=1 SHALL enter HOLD at that edge with no tick; count and prescaler SHALL be frozen while in HOLD.
REQ-021 In HOLD, pause=0 SHALL return the FSM to RUN; the prescaler SHALL resume from its frozen value.
REQ-022 On a tick with count==1 and auto_reload=0, the block SHALL set count to 0, pulse done=1 for exactly one cycle and enter IDLE (busy=0 at the same edge).
REQ-023 On a tick with count==1 and auto_reload=1, the block SHALL load count from reload, pulse done=1 for one cycle and stay in RUN; count never displays 0 in this case.
REQ-024 auto_reload SHALL be sampled only at the terminal tick.
REQ-025 All arithmetic SHALL be unsigned and WIDTH-bit; count SHALL never underflow below 0.
REQ-026 A load in RUN or HOLD SHALL abort the run without a done pulse.

Reset
REQ-027 reset=0 SHALL immediately, without waiting for clock, force count=0, reload=0, prescaler=0, state=IDLE, busy=0 and done=0.
REQ-028 reset asserted mid-run SHALL discard the run; after release, the block SHALL remain in IDLE until the next load and start.
REQ-029 All inputs SHALL be ignored while reset=0.

Verification
REQ-030 PRESCALE=1, load 3, start at edge E -> count 2,1,0 at E+1..E+3; done=1 only after E+3; busy 1 from E through E+2, 0 after E+3.
REQ-031 PRESCALE=4, load 2, start -> count decrements at E+4 and E+8; done pulses after E+8.
REQ-032 PRESCALE=1, load 5, start, pause high for 3 cycles after the first tick -> count holds at 4 for 3 cycles, busy stays 1, then resumes 3,2,1,0.
REQ-033 PRESCALE=1, load 2, auto_reload=1, run 6 cycles -> count 1,2,1,2,1,2 and done pulses at every 1->2 transition.
REQ-034 Load 0 then start -> stays in IDLE, busy=0, done=0; load 200 during RUN -> count=200, IDLE, no done.
REQ-035 Drive reset=0 between clock edges mid-run -> count=0, busy=0 immediately; after release, start without load is ignored.
